// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I sequencer and its datapath.
// The controller owns the master side: it reads IR/flags and drives every select and enable.
interface multicycle_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          instr;
    logic                 EQ;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 IRWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ALUctrl;
    logic [1:0]           ImmSrc;
    logic                 illegal_instr;
    logic [3:0]           state;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  instr, EQ, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, illegal_instr, state, instret
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, illegal_instr, state, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Moore decode of state, memory-ready stalls, and a retired-instruction counter.
module multicycle_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q;
    logic                 retire;
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 f7b5;
    logic                 unused_instr_bits;

    assign op                = bus.instr[6:0];
    assign funct3            = bus.instr[14:12];
    assign f7b5              = bus.instr[30];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // Subtract only for R-type with funct7[5] set; addi never subtracts.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic b30,
                                              input logic rtype);
        case (f3)
            3'b000:  alu_decode = (rtype && b30) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_decode = ALU_SLT;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d           = FETCH;
        retire            = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ResultSrc     = 2'b00;
        bus.ALUSrcA       = 2'b00;
        bus.ALUSrcB       = 2'b00;
        bus.ALUctrl       = ALU_ADD;
        bus.illegal_instr = 1'b0;

        case (op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase

        case (state_q)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      bus.illegal_instr = 1'b1;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_d     = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                retire        = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                retire       = bus.mem_ready;
                state_d      = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUctrl = alu_decode(funct3, f7b5, 1'b1);
                state_d     = ALUWB;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUctrl = alu_decode(funct3, f7b5, 1'b0);
                state_d     = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
            end
            BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUctrl = ALU_SUB;
                bus.PCWrite = bus.EQ;
                retire      = 1'b1;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                state_d     = ALUWB;
            end
            default: state_d = FETCH;
        endcase

        // Reset aborts whatever is in flight: no writes, no retirement.
        if (rst) begin
            retire            = 1'b0;
            bus.PCWrite       = 1'b0;
            bus.AdrSrc        = 1'b0;
            bus.IRWrite       = 1'b0;
            bus.MemWrite      = 1'b0;
            bus.RegWrite      = 1'b0;
            bus.ResultSrc     = 2'b00;
            bus.ALUSrcA       = 2'b00;
            bus.ALUSrcB       = 2'b00;
            bus.ALUctrl       = ALU_ADD;
            bus.ImmSrc        = 2'b00;
            bus.illegal_instr = 1'b0;
        end
    end

    assign bus.state   = state_q;
    assign bus.instret = instret_q;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multi-cycle variant of the RV32I core: one shared ALU, one unified instruction/data memory, instruction register (IR) and OldPC/ALUOut/Data holding registers.
- Drives every mux select and write enable of the multi-cycle datapath, one state per cycle.
- Stalls on the memory ready handshake and keeps a retired-instruction counter.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current IR contents.
- EQ  in  1  ALU zero/equality flag.
- mem_ready  in  1  memory completes the access this cycle.
- PCWrite  out  1  PC register write enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  IR and OldPC write enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  Result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  SrcA select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  SrcB select: 00 RD2, 01 ImmExt, 10 constant 4.
- ALUctrl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal_instr  out  1  pulses in DECODE when the opcode is unsupported.
- state  out  4  current state encoding, for debug.
- instret  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset: clk and rst only; reset is synchronous, active-high.
  - Next state is FETCH (0) and instret is cleared to 0.
  - While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr are forced 0 combinationally. All other outputs are 0.
  - rst asserted in any state, including mid-access, aborts the instruction with no write.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 go to FETCH with all enables 0.
- Output timing: outputs are a Moore decode of state. Exceptions: ALUctrl and ImmSrc also depend on instr; PCWrite in BEQ depends on EQ; enables gated by mem_ready where noted.
- Outputs per state (unlisted outputs are 0; ALUctrl defaults to add):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - otherwise illegal_instr=1 and → FETCH
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. → MEMREAD if opcode=lw, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Wait while mem_ready=0, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. → FETCH and retire.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1. On mem_ready=1 → FETCH and retire.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU decode. → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU decode. → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. → FETCH and retire.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=EQ. → FETCH and retire.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. → ALUWB (writes PC+4 to rd; retire happens there, not in JAL).
- ALU decode (uses funct3=instr[14:12], f7b5=instr[30]):
  - 000: sub only when R-type and f7b5=1, else add.
  - 010 → slt, 110 → or, 111 → and.
  - Any other funct3 → add.
- ImmSrc comes from the opcode in every state: I-ALU/lw → 00, sw → 01, beq → 10, jal → 11, else 00.
- instret: increments by 1 on the clock edge that leaves a retiring state (MEMWB, MEMWRITE with mem_ready, ALUWB, BEQ).
  - Wraps from all-ones to 0.
  - Illegal instructions and reset-aborted instructions do not count.
- Latencies with mem_ready held at 1, in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4. Each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset then instr=add x3,x1,x2 (0x002081B3), mem_ready=1 → state sequence 0,1,6,8,0. ALUctrl=000 in EXECUTER. RegWrite=1 only in ALUWB. instret=1.
- instr=sub (0x402081B3) → ALUctrl=001 in EXECUTER. instr=addi with funct3=000 and instr[30]=1 → ALUctrl=000.
- lw with mem_ready=0 for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. IRWrite/PCWrite high only on the ready FETCH cycle. RegWrite=1 in MEMWB.
- beq with EQ=1 → PCWrite=1 in BEQ. With EQ=0 → PCWrite=0. Both take 3 cycles; instret increments by 1 each.
- opcode 0x7F → illegal_instr=1 for one cycle in DECODE, back to FETCH, instret unchanged. rst=1 during MEMWRITE with mem_ready=1 → MemWrite=0, next state 0, instret=0.
- Preload instret to all-ones via 2^CNT_WIDTH−1 retirements (use CNT_WIDTH=4, 15 retirements), retire one more → instret=0.
